// File: rtl/composite_pkg.sv
// Shared widths, types, state encoding and saturation helper for the composite level clamp.
// Pure declarations: no logic, no latency.
package composite_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int OUT_W_DEF  = 13;

  typedef logic [11:0]        adc_sample_t;
  typedef logic signed [12:0] pix_signed_t;

  typedef enum logic [1:0] {
    IDLE,
    PORCH_WAIT,
    ACCUM,
    DONE
  } clamp_state_t;

  // Clamp a signed value to the range of a width-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/composite_level_clamp_level_iir.sv
// Single-pole IIR level estimator: est += (meas - est) >>> SHIFT on each load strobe.
// Updated estimate is visible the cycle after load; no backpressure.
module level_iir #(
  parameter int W         = 12,
  parameter int SHIFT     = 2,
  parameter int RESET_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] meas,
  output logic [W-1:0] est
);

  logic signed [W:0] diff;
  logic signed [W:0] step;

  // The step lies between 0 and diff, so est + step never leaves [0, 2**W-1].
  assign diff = $signed({1'b0, meas}) - $signed({1'b0, est});
  assign step = diff >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est <= W'(RESET_VAL);
    end else if (load) begin
      est <= W'($signed({1'b0, est}) + step);
    end
  end

endmodule

// File: rtl/composite_level_clamp.sv
// Black-level clamp: tracks sync tip and back-porch black per line, emits gain-scaled saturated pixels.
// Pixel latency 2 clk after sample_valid; no backpressure, one sample per strobe.
module composite_level_clamp
  import composite_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OUT_W       = OUT_W_DEF,
  parameter int GAIN_SHIFT  = 1,
  parameter int BLACK_CODE  = -1024,
  parameter int BP_START    = 40,
  parameter int BP_LEN_LOG2 = 5,
  parameter int IIR_SHIFT   = 2,
  parameter int BLACK_INIT  = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_valid,
  input  logic [DATA_W-1:0]       adc_data,
  input  logic                    adc_otr,
  input  logic                    h_sync_pulse,
  output logic signed [OUT_W-1:0] pixel_out,
  output logic                    pixel_valid,
  output logic [DATA_W-1:0]       sync_floor,
  output logic [DATA_W-1:0]       black_level,
  output logic                    levels_valid,
  output logic                    otr_seen
);

  localparam int SAT_W = OUT_W - 1;
  localparam int IDX_W = $clog2(BP_START + 1) + 1;
  localparam int ACC_W = DATA_W + BP_LEN_LOG2;
  localparam logic [DATA_W-1:0]      ALL_ONES = '1;
  localparam logic [IDX_W-1:0]       IDX_MAX  = '1;
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(BP_START - 1);
  localparam logic [BP_LEN_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [OUT_W+2:0] BLACK_V = (OUT_W+3)'(BLACK_CODE);
  localparam logic signed [OUT_W-1:0] PIX_MAX = OUT_W'((2 ** (SAT_W - 1)) - 1);

  clamp_state_t            state, state_nxt, cur_state;
  logic [IDX_W-1:0]        idx, idx_nxt, cur_idx;
  logic [BP_LEN_LOG2-1:0]  cnt, cnt_nxt, cur_cnt;
  logic [ACC_W-1:0]        acc, acc_nxt, cur_acc, acc_sum;
  logic                    black_load;
  logic [DATA_W-1:0]       black_meas;
  logic                    sync_load;
  logic [DATA_W-1:0]       line_min;
  logic                    line_otr;
  logic [1:0]              done_cnt;
  logic                    sample_ok;

  logic                    s1_vld;
  logic                    s1_otr;
  logic [DATA_W-1:0]       s1_dat;
  logic signed [DATA_W:0]  diff;
  logic signed [OUT_W+2:0] diff_ext;
  logic signed [OUT_W+2:0] scaled;
  logic signed [OUT_W-1:0] pix_nxt;

  assign sample_ok = sample_valid & ~adc_otr;

  // A line start takes effect first, so a coincident sample is index 0 of the new line.
  always_comb begin
    cur_state = state;
    cur_idx   = idx;
    cur_cnt   = cnt;
    cur_acc   = acc;
    if (h_sync_pulse) begin
      cur_state = PORCH_WAIT;
      cur_idx   = '0;
      cur_cnt   = '0;
      cur_acc   = '0;
    end
    state_nxt  = cur_state;
    idx_nxt    = cur_idx;
    cnt_nxt    = cur_cnt;
    acc_nxt    = cur_acc;
    acc_sum    = cur_acc + ACC_W'(adc_data);
    black_load = 1'b0;
    if (sample_valid) begin
      case (cur_state)
        PORCH_WAIT: begin
          if (cur_idx != IDX_MAX) idx_nxt = cur_idx + 1'b1;
          if (cur_idx == IDX_LAST) state_nxt = ACCUM;
        end
        ACCUM: begin
          if (!adc_otr) begin
            if (cur_cnt == CNT_LAST) begin
              black_load = 1'b1;
              state_nxt  = DONE;
              acc_nxt    = '0;
              cnt_nxt    = '0;
            end else begin
              acc_nxt = acc_sum;
              cnt_nxt = cur_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign black_meas = DATA_W'(acc_sum >> BP_LEN_LOG2);
  assign sync_load  = h_sync_pulse && (line_min != ALL_ONES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_min <= ALL_ONES;
      line_otr <= 1'b0;
      otr_seen <= 1'b0;
    end else if (h_sync_pulse) begin
      line_min <= sample_ok ? adc_data : ALL_ONES;
      line_otr <= sample_valid & adc_otr;
      otr_seen <= line_otr;
    end else begin
      if (sample_ok && (adc_data < line_min)) line_min <= adc_data;
      if (sample_valid && adc_otr) line_otr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt     <= '0;
      levels_valid <= 1'b0;
    end else if (black_load && !levels_valid) begin
      done_cnt <= done_cnt + 1'b1;
      if (done_cnt == 2'd3) levels_valid <= 1'b1;
    end
  end

  level_iir #(.W(DATA_W), .SHIFT(IIR_SHIFT), .RESET_VAL(0)) u_sync_iir (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sync_load),
    .meas  (line_min),
    .est   (sync_floor)
  );

  level_iir #(.W(DATA_W), .SHIFT(IIR_SHIFT), .RESET_VAL(BLACK_INIT)) u_black_iir (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (black_load),
    .meas  (black_meas),
    .est   (black_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_otr <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= sample_valid;
      if (sample_valid) begin
        s1_otr <= adc_otr;
        s1_dat <= adc_data;
      end
    end
  end

  always_comb begin
    diff     = $signed({1'b0, s1_dat}) - $signed({1'b0, black_level});
    diff_ext = (OUT_W+3)'(diff);
    scaled   = (diff_ext <<< GAIN_SHIFT) + BLACK_V;
    pix_nxt  = s1_otr ? PIX_MAX : OUT_W'(sat_signed(32'(scaled), SAT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= s1_vld;
      if (s1_vld) pixel_out <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_composite_level_clamp.sv
// Randomized bench for composite_level_clamp: line-level reference model feeds a pixel scoreboard
// drained by an independent monitor; level outputs are compared after every stimulus event.
module tb_composite_level_clamp;
  import composite_pkg::*;

  localparam int BP_START   = 40;
  localparam int WIN        = 32;
  localparam int IIR_SHIFT  = 2;
  localparam int BLACK_INIT = 512;
  localparam int GAIN       = 2;
  localparam int BLACK_CODE = -1024;
  localparam int PIX_HI     = 2047;
  localparam int PIX_LO     = -2048;
  localparam int NO_MIN     = 4095;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sample_valid = 1'b0;
  adc_sample_t        adc_data = '0;
  logic               adc_otr = 1'b0;
  logic               h_sync_pulse = 1'b0;
  logic signed [12:0] pixel_out;
  logic               pixel_valid;
  logic [11:0]        sync_floor;
  logic [11:0]        black_level;
  logic               levels_valid;
  logic               otr_seen;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int pix;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  int  m_black, m_sync, m_min, m_idx, m_done_lines;
  bit  m_active, m_done, m_line_otr, m_otr_seen;
  int  m_win[$];

  composite_level_clamp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .adc_data     (adc_data),
    .adc_otr      (adc_otr),
    .h_sync_pulse (h_sync_pulse),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .sync_floor   (sync_floor),
    .black_level  (black_level),
    .levels_valid (levels_valid),
    .otr_seen     (otr_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > PIX_HI) return PIX_HI;
    if (v < PIX_LO) return PIX_LO;
    return v;
  endfunction

  task automatic model_reset();
    m_black = BLACK_INIT;
    m_sync = 0;
    m_min = NO_MIN;
    m_idx = 0;
    m_done_lines = 0;
    m_active = 0;
    m_done = 0;
    m_line_otr = 0;
    m_otr_seen = 0;
    m_win.delete();
  endtask

  // Line-level behaviour: a line is the sample list since the last sync; the black window
  // is the first 32 in-range samples at position >= BP_START.
  task automatic model_event(input int v, input bit otr, input bit hs, input bit sv, output int pix);
    int sum;
    pix = 0;
    if (hs) begin
      if (m_min != NO_MIN) m_sync = m_sync + ((m_min - m_sync) >>> IIR_SHIFT);
      m_otr_seen = m_line_otr;
      m_line_otr = 0;
      m_min = NO_MIN;
      m_idx = 0;
      m_active = 1;
      m_done = 0;
      m_win.delete();
    end
    if (sv) begin
      if (otr) m_line_otr = 1;
      else if (v < m_min) m_min = v;
      if (m_active && !m_done && !otr && m_idx >= BP_START) begin
        m_win.push_back(v);
        if (m_win.size() == WIN) begin
          sum = 0;
          foreach (m_win[i]) sum += m_win[i];
          m_black = m_black + (((sum / WIN) - m_black) >>> IIR_SHIFT);
          m_done = 1;
          m_done_lines++;
        end
      end
      if (m_active) m_idx++;
      pix = otr ? PIX_HI : clamp((v - m_black) * GAIN + BLACK_CODE);
    end
  endtask

  task automatic check_levels();
    check("black_level", int'(black_level), m_black);
    check("sync_floor", int'(sync_floor), m_sync);
    check("otr_seen", int'(otr_seen), int'(m_otr_seen));
    check("levels_valid", int'(levels_valid), (m_done_lines >= 4) ? 1 : 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pixel_out"}, int'(pixel_out), 0);
    check({tag, "_pixel_valid"}, int'(pixel_valid), 0);
    check({tag, "_sync_floor"}, int'(sync_floor), 0);
    check({tag, "_black_level"}, int'(black_level), BLACK_INIT);
    check({tag, "_levels_valid"}, int'(levels_valid), 0);
    check({tag, "_otr_seen"}, int'(otr_seen), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int v, input bit otr, input bit hs);
    int   pix;
    exp_t e;
    model_event(v, otr, hs, 1'b1, pix);
    sample_valid = 1'b1;
    adc_data = 12'(v);
    adc_otr = otr;
    h_sync_pulse = hs;
    e.pix = pix;
    e.cyc = cyc + 2;
    exp_q.push_back(e);
    step();
    sample_valid = 1'b0;
    adc_otr = 1'b0;
    h_sync_pulse = 1'b0;
    check_levels();
  endtask

  task automatic hs_only();
    int pix;
    model_event(0, 1'b0, 1'b1, 1'b0, pix);
    h_sync_pulse = 1'b1;
    step();
    h_sync_pulse = 1'b0;
    check_levels();
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL pixel_missing: no pixel_valid at cycle %0d, expected pixel %0d", e.cyc, e.pix);
    end
    if (rst_n && pixel_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_unexpected: pixel_valid with pixel %0d at cycle %0d, none expected",
                 pixel_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(pixel_out) != e.pix || e.cyc != cyc) begin
          miscompares++;
          $display("FAIL pixel: got %0d at cycle %0d, expected %0d at cycle %0d",
                   pixel_out, cyc, e.pix, e.cyc);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    int len;
    model_reset();
    gap(3);
    check_reset("por");
    rst_n = 1'b1;
    gap(2);

    // Constant mid-grey with default black: every pixel is 1024.
    for (int i = 0; i < 20; i++) begin
      send(1536, 1'b0, 1'b0);
      gap($urandom_range(0, 2));
    end
    // Saturation at both ends.
    send(4095, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    gap(3);

    // Four clean lines: sync tip 300, porch 600.
    for (int ln = 0; ln < 4; ln++) begin
      hs_only();
      if (ln == 1) check("sync_floor_line_min_300", int'(sync_floor), 75);
      for (int i = 0; i < 80; i++) send((i < 10) ? 300 : 600, 1'b0, 1'b0);
      if (ln == 0) check("black_after_line1", int'(black_level), 534);
      if (ln == 2) check("levels_valid_after_3", int'(levels_valid), 0);
      if (ln == 3) check("levels_valid_after_4", int'(levels_valid), 1);
    end
    // Empty line leaves sync_floor untouched.
    hs_only();
    saved = m_sync;
    hs_only();
    check("sync_floor_empty_line", int'(sync_floor), saved);

    // Short line aborted mid-window, next line starts on a coincident sample.
    hs_only();
    saved = m_black;
    for (int i = 0; i < 51; i++) send($urandom_range(200, 900), 1'b0, 1'b0);
    send($urandom_range(200, 900), 1'b0, 1'b1);
    check("black_after_abort", int'(black_level), saved);
    for (int i = 1; i < 80; i++) send($urandom_range(200, 900), 1'b0, 1'b0);

    // Out-of-range samples inside the window.
    hs_only();
    for (int i = 0; i < 100; i++)
      send($urandom_range(300, 800), (i == 45 || i == 50 || i == 60), 1'b0);
    hs_only();
    check("otr_seen_set", int'(otr_seen), 1);
    for (int i = 0; i < 20; i++) send($urandom_range(300, 800), 1'b0, 1'b0);
    hs_only();
    check("otr_seen_clear", int'(otr_seen), 0);

    // Random lines.
    for (int ln = 0; ln < 40; ln++) begin
      len = $urandom_range(0, 130);
      if (len > 0 && $urandom_range(0, 1) == 1) begin
        send($urandom_range(0, 4095), ($urandom_range(0, 15) == 0), 1'b1);
        len--;
      end else begin
        hs_only();
      end
      for (int i = 0; i < len; i++) begin
        send($urandom_range(0, 4095), ($urandom_range(0, 15) == 0), 1'b0);
        gap($urandom_range(0, 1));
      end
    end

    // Reset in the middle of the porch window.
    hs_only();
    for (int i = 0; i < 50; i++) send($urandom_range(300, 800), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_reset();
    check_reset("mid");
    gap(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send(1536, 1'b0, 1'b0);

    gap(4);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
